// File: rtl/uart_tx_arbiter_pkg.sv
// Types shared by the UART TX arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;
`include "uart_defs.vh"

    typedef enum logic [2:0] {
        ST_IDLE       = `UART_ARB_IDLE,
        ST_LAUNCH     = `UART_ARB_LAUNCH,
        ST_WAIT_START = `UART_ARB_WAIT_START,
        ST_WAIT_END   = `UART_ARB_WAIT_END
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_defs.vh
// Shared UART state encodings for the TX scheduler FSM.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH
`define UART_ARB_IDLE       3'b000
`define UART_ARB_LAUNCH     3'b001
`define UART_ARB_WAIT_START 3'b010
`define UART_ARB_WAIT_END   3'b100
`endif

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request bit above i_last, wrapping.
module rr_priority_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    // Scan from last+1 upward; the first hit wins and later hits are ignored.
    always_comb begin
        logic [ID_W-1:0] cand;
        o_winner = '0;
        o_any    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[cand] && !o_any) begin
                o_winner = cand;
                o_any    = 1'b1;
            end else begin
                o_winner = o_winner;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX serializer among NUM_REQ producers.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int DATA_WIDTH    = 8,
    parameter  int START_TIMEOUT = 16,
    localparam int ID_W          = id_width(NUM_REQ),
    localparam int CNT_W         = $clog2(START_TIMEOUT)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic                          i_tx_busy,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_data_valid,
    output logic [ID_W-1:0]               o_active_id,
    output logic                          o_arb_busy,
    output logic                          o_timeout_err
);

    arb_state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]         r_last, w_last_nxt;
    logic [ID_W-1:0]         r_active_id, w_active_id_nxt;
    logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data_nxt;
    logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_err, w_err_nxt;
    logic                    r_arb_busy;
    logic [ID_W-1:0]         w_win;
    logic                    w_any;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // Next-state and next-output decode; every output is re-registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_active_id_nxt = r_active_id;
        w_tx_data_nxt   = r_tx_data;
        w_grant_nxt     = '0;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A busy serializer is never interrupted, even by a frame we did not start.
                if (w_any && !i_tx_busy) begin
                    w_state_nxt     = ST_LAUNCH;
                    w_active_id_nxt = w_win;
                    w_tx_data_nxt   = i_req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                w_valid_nxt              = 1'b1;
                w_grant_nxt[r_active_id] = 1'b1;
                w_cnt_nxt                = '0;
                w_state_nxt              = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (i_tx_busy) begin
                    w_state_nxt = ST_WAIT_END;
                end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_last_nxt  = r_active_id;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_END: begin
                if (!i_tx_busy) begin
                    w_last_nxt  = r_active_id;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_END;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cnt_nxt       = '0;
                w_active_id_nxt = '0;
                w_tx_data_nxt   = '0;
            end
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_last      <= ID_W'(NUM_REQ - 1);
            r_active_id <= '0;
            r_tx_data   <= '0;
            r_grant     <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_arb_busy  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_active_id <= w_active_id_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_grant     <= w_grant_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_arb_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_grant         = r_grant;
    assign o_tx_data       = r_tx_data;
    assign o_tx_data_valid = r_valid;
    assign o_active_id     = r_active_id;
    assign o_arb_busy      = r_arb_busy;
    assign o_timeout_err   = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter with a simple serializer model.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        i_rst;
    logic [3:0]  i_req;
    logic [31:0] i_req_data;
    logic        i_tx_busy;
    logic [3:0]  o_grant;
    logic [7:0]  o_tx_data;
    logic        o_tx_data_valid;
    logic [1:0]  o_active_id;
    logic        o_arb_busy;
    logic        o_timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] byte_of [4];

    typedef struct {
        logic [3:0] req;
        int         busy_len;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs [14];

    uart_tx_arbiter dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_req           (i_req),
        .i_req_data      (i_req_data),
        .i_tx_busy       (i_tx_busy),
        .o_grant         (o_grant),
        .o_tx_data       (o_tx_data),
        .o_tx_data_valid (o_tx_data_valid),
        .o_active_id     (o_active_id),
        .o_arb_busy      (o_arb_busy),
        .o_timeout_err   (o_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One grant + serializer frame; returns at a falling edge with the arbiter in IDLE.
    task automatic run_frame(input logic [3:0] req, input int busy_len, input logic [1:0] exp_id,
                             input bit withdraw, input string name);
        int t;
        logic [3:0] exp_g;
        exp_g = 4'b0001 << exp_id;
        i_req = req;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_tx_data_valid && t < 20);
        chk({name, " latency"}, 32'(t), 32'd2);
        chk({name, " grant"}, 32'(o_grant), 32'(exp_g));
        chk({name, " valid"}, 32'(o_tx_data_valid), 32'd1);
        chk({name, " data"}, 32'(o_tx_data), 32'(byte_of[exp_id]));
        chk({name, " id"}, 32'(o_active_id), 32'(exp_id));
        chk({name, " arb_busy"}, 32'(o_arb_busy), 32'd1);
        @(negedge clk);
        chk({name, " valid_pulse"}, 32'({o_grant, o_tx_data_valid}), 32'd0);
        i_tx_busy = 1'b1;
        for (int c = 0; c < busy_len; c++) begin
            @(negedge clk);
            if (withdraw && c == 1) i_req = req & ~exp_g;
        end
        i_tx_busy = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (o_arb_busy && t < 20);
        chk({name, " back_idle"}, 32'(o_arb_busy), 32'd0);
        chk({name, " data_hold"}, 32'(o_tx_data), 32'(byte_of[exp_id]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int g;
        clk        = 1'b0;
        i_rst      = 1'b1;
        i_req      = 4'b0000;
        i_tx_busy  = 1'b0;
        byte_of    = '{8'h10, 8'h21, 8'hA5, 8'h3C};
        i_req_data = {8'h3C, 8'hA5, 8'h21, 8'h10};

        vecs[0]  = '{4'b1111, 4, 2'd0};
        vecs[1]  = '{4'b1111, 4, 2'd1};
        vecs[2]  = '{4'b1111, 4, 2'd2};
        vecs[3]  = '{4'b1111, 4, 2'd3};
        vecs[4]  = '{4'b1111, 3, 2'd0};
        vecs[5]  = '{4'b1111, 3, 2'd1};
        vecs[6]  = '{4'b1111, 3, 2'd2};
        vecs[7]  = '{4'b1111, 3, 2'd3};
        vecs[8]  = '{4'b0101, 5, 2'd0};
        vecs[9]  = '{4'b0101, 5, 2'd2};
        vecs[10] = '{4'b0100, 10, 2'd2};
        vecs[11] = '{4'b1010, 2, 2'd3};
        vecs[12] = '{4'b0011, 2, 2'd0};
        vecs[13] = '{4'b1000, 6, 2'd3};

        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("reset grant", 32'(o_grant), 32'd0);
        chk("reset data", 32'(o_tx_data), 32'd0);
        chk("reset valid", 32'(o_tx_data_valid), 32'd0);
        chk("reset id", 32'(o_active_id), 32'd0);
        chk("reset arb_busy", 32'(o_arb_busy), 32'd0);
        chk("reset err", 32'(o_timeout_err), 32'd0);

        for (int v = 0; v < 14; v++) begin
            run_frame(vecs[v].req, vecs[v].busy_len, vecs[v].exp_id, 1'b0, $sformatf("vec%0d", v));
        end

        // Serializer never starts: error on the 16th WAIT_START cycle, byte dropped.
        i_req = 4'b0010;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_tx_data_valid && t < 20);
        chk("timeout grant", 32'(o_grant), 32'h2);
        i_req = 4'b0000;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_timeout_err && t < 40);
        chk("timeout cycles", 32'(t), 32'd16);
        chk("timeout idle", 32'(o_arb_busy), 32'd0);
        @(negedge clk);
        chk("timeout pulse", 32'(o_timeout_err), 32'd0);
        run_frame(4'b1111, 3, 2'd2, 1'b0, "after_timeout");

        // Requester 1 withdraws during its own frame: no further grant.
        run_frame(4'b0010, 5, 2'd1, 1'b1, "withdraw");
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_grant != 4'b0000 || o_tx_data_valid) g++;
        end
        chk("withdraw no_regrant", 32'(g), 32'd0);

        // Reset while in WAIT_END, then release with the serializer still busy.
        i_req = 4'b1000;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_tx_data_valid && t < 20);
        chk("rst_mid grant", 32'(o_grant), 32'h8);
        @(negedge clk);
        i_tx_busy = 1'b1;
        i_req     = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_mid in_frame", 32'(o_arb_busy), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_mid outputs", 32'({o_grant, o_tx_data, o_tx_data_valid, o_active_id,
                                     o_arb_busy, o_timeout_err}), 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        i_req = 4'b0001;
        g = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_tx_data_valid || o_arb_busy) g++;
        end
        chk("rst_mid wait_busy", 32'(g), 32'd0);
        i_tx_busy = 1'b0;
        run_frame(4'b0001, 3, 2'd0, 1'b0, "post_reset");
        i_req = 4'b0000;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART TX serializer among `NUM_REQ` byte producers. It picks one pending requester, latches its byte, and launches it with a one-cycle `TX_DATA_VALID` strobe. It then tracks the serializer's `TX_BUSY` through the whole frame before granting again. It sits between the producer blocks and the TX top level, on the same clock as the serializer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: frame payload width.
- `START_TIMEOUT`, 16: cycles allowed for `TX_BUSY` to rise after launch, ≥2.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `REQ` in `NUM_REQ`: per-requester "byte pending", level.
- `REQ_DATA` in `NUM_REQ*DATA_WIDTH`: requester i's byte is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `TX_BUSY` in 1: serializer frame in progress.
- `GRANT` out `NUM_REQ`: one-hot, one-cycle pulse; the byte of the granted requester was consumed.
- `TX_DATA` out `DATA_WIDTH`: latched byte to the serializer.
- `TX_DATA_VALID` out 1: one-cycle launch strobe.
- `ACTIVE_ID` out clog2(`NUM_REQ`): index of the requester currently owning the TX.
- `ARB_BUSY` out 1: high in every state except IDLE.
- `TIMEOUT_ERR` out 1: one-cycle pulse when the serializer never started.

## Operation
- All outputs are driven from registers.
- Reset values: `GRANT`=0, `TX_DATA`=0, `TX_DATA_VALID`=0, `ACTIVE_ID`=0, `ARB_BUSY`=0, `TIMEOUT_ERR`=0. The state register resets to IDLE. The `last` pointer resets to `NUM_REQ-1`, so requester 0 has first priority.
- IDLE:
  - If `|REQ` and `!TX_BUSY`, the winner is the first set bit of `REQ` searching upward from `(last+1) mod NUM_REQ`, wrapping.
  - Latch `TX_DATA` and `ACTIVE_ID` from the winner, then go to LAUNCH.
  - If `TX_BUSY` is high, stay in IDLE; a foreign or stale frame is never interrupted.
- LAUNCH: assert `TX_DATA_VALID`=1 and `GRANT[ACTIVE_ID]`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_START.
- WAIT_START:
  - If `TX_BUSY`=1, go to WAIT_END.
  - Otherwise, when the counter reaches `START_TIMEOUT-1`, pulse `TIMEOUT_ERR`, set `last`=`ACTIVE_ID`, and go to IDLE. The byte is dropped and is not retried.
  - Otherwise, increment the counter.
- WAIT_END: when `TX_BUSY`=0, set `last`=`ACTIVE_ID` and go to IDLE.
- `REQ` is sampled only in IDLE. A requester dropping `REQ` in any other state has no effect on the frame in flight.
- `TX_DATA` holds its value until the next IDLE→LAUNCH transition.
- Reset mid-frame returns to IDLE immediately and clears all outputs. The serializer is not aborted. After reset release, the arbiter waits in IDLE for `TX_BUSY`=0.

## Timing
- Request visible at edge k in IDLE with `TX_BUSY`=0: `TX_DATA_VALID` and `GRANT` are high in the cycle after edge k+1.
- Minimum re-grant spacing: one frame duration plus 2 cycles (WAIT_END→IDLE, IDLE→LAUNCH).
- A requester whose `REQ` is still high in the cycle after its `GRANT` pulse is treated as having a new byte.
- With all requesters requesting continuously, grant order is 0,1,2,3,0,… No requester waits more than `NUM_REQ-1` frames.
- `START_TIMEOUT` counts WAIT_START cycles exactly. `TIMEOUT_ERR` rises on the `START_TIMEOUT`-th WAIT_START cycle.

## Structure
- Put the state encodings in the shared UART defines include `uart_defs.vh`:
  - IDLE=3'b000, LAUNCH=3'b001, WAIT_START=3'b010, WAIT_END=3'b100.
  - Unused encodings recover to IDLE with all outputs 0.
- Sub-module `rr_priority_picker`: combinational; inputs `REQ` and `last`; outputs winner index and `any` flag. It is reusable by future RX-side schedulers.
- The FSM, counter, and data latch live in `uart_tx_arbiter`.

## Test plan
- Reset check: assert `RST` mid-WAIT_END → all outputs 0 within the same cycle. After release with `TX_BUSY`=1, no launch occurs until `TX_BUSY` falls.
- Single request: `REQ`=4'b0100, byte 8'hA5, serializer model with `TX_BUSY` high for 10 cycles → one `GRANT`=4'b0100 pulse, `TX_DATA`=8'hA5, `TX_DATA_VALID` one cycle, `ACTIVE_ID`=2.
- Fairness: `REQ`=4'b1111 held for 8 frames → grants in order 0,1,2,3,0,1,2,3. Each `TX_DATA` matches its requester's byte.
- Wrap and skip: after a grant to 3, `REQ`=4'b0101 → next grant 0, then 2.
- Timeout: `TX_BUSY` held 0 after launch → `TIMEOUT_ERR` pulses on the 16th WAIT_START cycle, arbiter returns to IDLE, and `last` advances.
- Withdrawal: requester 1 drops `REQ` during WAIT_END of its own frame → frame completes normally and no extra grant is issued to 1.
